// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends a 24-bit frame as three back-to-back 8N1 UART characters
//   clock        system clock, rising edge
//   reset        synchronous active-low reset
//   partida      start request, sampled only while idle
//   dados        frame; byte 0 = dados[23:16] goes out first
//   saidaSerial  registered UART TX line, idles high
//   ocupado      high while a frame is in progress
//   pronto       one-cycle pulse when the last stop bit completes
module uart_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        partida,
    input  logic [23:0] dados,
    output logic        saidaSerial,
    output logic        ocupado,
    output logic        pronto
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

    state_t      state;
    logic [23:0] shiftReg;
    logic [BW-1:0] baudCnt;
    logic [2:0]  bitIdx;
    logic [1:0]  byteIdx;
    logic [7:0]  curByte;
    logic        bitEnd;

    always_comb begin
        curByte = byteIdx == 2'd0 ? shiftReg[23:16] :
                  byteIdx == 2'd1 ? shiftReg[15:8] : shiftReg[7:0];
        bitEnd  = baudCnt == LAST;
    end

    // Each output bit is driven together with the state change so the line
    // stays a registered output and every bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            shiftReg    <= '0;
            baudCnt     <= '0;
            bitIdx      <= '0;
            byteIdx     <= '0;
            saidaSerial <= 1'b1;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (state)
                IDLE: begin
                    baudCnt     <= '0;
                    bitIdx      <= '0;
                    byteIdx     <= '0;
                    saidaSerial <= 1'b1;
                    if (partida) begin
                        shiftReg    <= dados;
                        state       <= START_BIT;
                        saidaSerial <= 1'b0;
                        ocupado     <= 1'b1;
                    end
                end
                START_BIT: begin
                    baudCnt <= bitEnd ? '0 : baudCnt + 1'b1;
                    if (bitEnd) begin
                        state       <= DATA_BITS;
                        saidaSerial <= curByte[0];
                    end
                end
                DATA_BITS: begin
                    baudCnt <= bitEnd ? '0 : baudCnt + 1'b1;
                    if (bitEnd) begin
                        if (bitIdx == 3'd7) begin
                            state       <= STOP_BIT;
                            bitIdx      <= '0;
                            saidaSerial <= 1'b1;
                        end else begin
                            bitIdx      <= bitIdx + 3'd1;
                            saidaSerial <= curByte[bitIdx + 3'd1];
                        end
                    end
                end
                STOP_BIT: begin
                    baudCnt <= bitEnd ? '0 : baudCnt + 1'b1;
                    if (bitEnd) begin
                        if (byteIdx == 2'd2) begin
                            state   <= IDLE;
                            byteIdx <= '0;
                            ocupado <= 1'b0;
                            pronto  <= 1'b1;
                        end else begin
                            // next start bit follows the stop bit with no gap
                            state       <= START_BIT;
                            byteIdx     <= byteIdx + 2'd1;
                            saidaSerial <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed and randomized frames checked against a bit-level frame model
module tb_uart_frame_tx;
    localparam int C = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        partida = 1'b0;
    logic [23:0] dados = '0;
    logic        saidaSerial, ocupado, pronto;
    int          checks = 0;
    int          failures = 0;

    uart_frame_tx #(.CLKS_PER_BIT(C)) dut (
        .clock(clock), .reset(reset), .partida(partida), .dados(dados),
        .saidaSerial(saidaSerial), .ocupado(ocupado), .pronto(pronto)
    );

    always #5 clock = ~clock;

    // Frame bit j of a 30-bit frame: start 0, 8 data bits LSB first, stop 1, per byte.
    function automatic logic expBit(input logic [23:0] d, input int j);
        int b = j / 10;
        int p = j % 10;
        logic [7:0] by = 8'((d >> (8 * (2 - b))) & 24'hFF);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idleCheck(input int n);
        repeat (n) begin
            @(negedge clock);
            chk("idle_line", saidaSerial, 1'b1);
            chk("idle_ocupado", ocupado, 1'b0);
            chk("idle_pronto", pronto, 1'b0);
        end
    endtask

    task automatic startFrame(input logic [23:0] d);
        @(negedge clock);
        dados = d;
        partida = 1'b1;
        @(posedge clock);
    endtask

    // Called just after the accepting edge; checks all 30*C cycles and the pronto cycle.
    task automatic checkFrame(input logic [23:0] d, input int abortAt, input int busyAt, input bit keep);
        for (int i = 0; i < 30 * C; i++) begin
            @(negedge clock);
            if (!keep) begin
                partida = 1'b0;
                dados = 24'($urandom);
            end
            chk("frame_line", saidaSerial, expBit(d, i / C));
            chk("frame_ocupado", ocupado, 1'b1);
            chk("frame_pronto", pronto, 1'b0);
            if (i == busyAt) begin
                partida = 1'b1;
                dados = 24'hAAAAAA;
            end
            if (i == abortAt) begin
                reset = 1'b0;
                @(negedge clock);
                chk("abort_line", saidaSerial, 1'b1);
                chk("abort_ocupado", ocupado, 1'b0);
                chk("abort_pronto", pronto, 1'b0);
                reset = 1'b1;
                return;
            end
        end
        @(negedge clock);
        chk("end_pronto", pronto, 1'b1);
        chk("end_ocupado", ocupado, 1'b0);
        chk("end_line", saidaSerial, 1'b1);
    endtask

    initial begin
        logic [23:0] r;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_line", saidaSerial, 1'b1);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_pronto", pronto, 1'b0);
        reset = 1'b1;
        idleCheck(20);

        startFrame(24'h123456);
        checkFrame(24'h123456, -1, -1, 1'b0);
        idleCheck(5);

        startFrame(24'h00FF00);
        checkFrame(24'h00FF00, -1, -1, 1'b0);
        idleCheck(3);

        startFrame(24'h010203);
        checkFrame(24'h010203, -1, 50, 1'b0);
        idleCheck(130);

        startFrame(24'hA5C30F);
        checkFrame(24'hA5C30F, -1, -1, 1'b1);
        checkFrame(24'hA5C30F, -1, -1, 1'b1);
        partida = 1'b0;
        idleCheck(10);

        repeat (3) begin
            r = 24'($urandom);
            startFrame(r);
            checkFrame(r, -1, -1, 1'b0);
            idleCheck(1 + int'($urandom_range(0, 6)));
        end

        r = 24'($urandom);
        startFrame(r);
        checkFrame(r, 37, -1, 1'b0);
        idleCheck(2 * 30 * C);

        r = 24'($urandom);
        startFrame(r);
        checkFrame(r, -1, -1, 1'b0);
        idleCheck(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
